// File: rtl/prio_encoder_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | enc_pkg : shared constants and helpers for prio_encoder_pipe        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package enc_pkg;

  localparam int MODE_FIXED  = 0;
  localparam int MODE_RR     = 1;
  localparam int MULTI_CNT_W = 16;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prio_encoder_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prio_encoder_pipe_if : request/result handshake bundle              |
// | Optional multi_cnt field with ENC_MULTI_CNT_EN. Rev 1.0             |
// +--------------------------------------------------------------------+
interface prio_encoder_pipe_if
  import enc_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_width(N)
) ();

  logic [N-1:0]  req;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] idx;
  logic          zero;
  logic          multi;
  logic          out_valid;
  logic          out_ready;
`ifdef ENC_MULTI_CNT_EN
  logic [MULTI_CNT_W-1:0] multi_cnt;
`endif

  modport slave (
    input  req, in_valid, out_ready,
    output in_ready, idx, zero, multi, out_valid
`ifdef ENC_MULTI_CNT_EN
    , output multi_cnt
`endif
  );

  modport master (
    output req, in_valid, out_ready,
    input  in_ready, idx, zero, multi, out_valid
`ifdef ENC_MULTI_CNT_EN
    , input multi_cnt
`endif
  );

endinterface
`default_nettype wire

// File: rtl/prio_encoder_pipe_search.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prio_enc_search : combinational winner search, zero and multi flags |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module prio_enc_search
  import enc_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int MODE      = MODE_FIXED,
  parameter  int LSB_FIRST = 1,
  localparam int IW        = idx_width(N)
) (
  input  wire logic [N-1:0]  req_i,
  input  wire logic [IW-1:0] base_i,
  output logic      [IW-1:0] idx_o,
  output logic               zero_o,
  output logic               multi_o
);

  assign zero_o  = ~|req_i;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = |(req_i & (req_i - N'(1)));

  if (MODE == MODE_RR) begin : g_rr
    logic          found;
    logic [IW:0]   pos;

    always_comb begin
      idx_o = '0;
      found = 1'b0;
      pos   = '0;
      for (int k = 0; k < N; k++) begin
        pos = {1'b0, base_i} + (IW+1)'(k);
        if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
        if (!found && req_i[pos[IW-1:0]]) begin
          idx_o = pos[IW-1:0];
          found = 1'b1;
        end
      end
    end
  end else begin : g_fixed
    logic w_unused_base;
    assign w_unused_base = ^base_i;

    if (LSB_FIRST != 0) begin : g_lsb
      always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
          if (req_i[i]) idx_o = IW'(i);
        end
      end
    end else begin : g_msb
      always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
          if (req_i[i]) idx_o = IW'(i);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/prio_encoder_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prio_encoder_pipe : registered N-input priority / round-robin       |
// | encoder with valid/ready output stage. ENC_MULTI_CNT_EN adds a      |
// | saturating multi-hot counter. Rev 1.0                               |
// +--------------------------------------------------------------------+
module prio_encoder_pipe
  import enc_pkg::*;
#(
  parameter int N         = 4,
  parameter int MODE      = MODE_FIXED,
  parameter int LSB_FIRST = 1
) (
  input wire logic          clk,
  input wire logic          rst,
  prio_encoder_pipe_if.slave bus
);

  localparam int IW = idx_width(N);

  logic          out_valid_q, out_valid_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          zero_q, zero_d;
  logic          multi_q, multi_d;

  logic [IW-1:0] w_ptr;
  logic [IW-1:0] w_win_idx;
  logic          w_win_zero;
  logic          w_win_multi;
  logic          w_in_ready;
  logic          w_accept;

  assign w_in_ready = !out_valid_q || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  prio_enc_search #(
    .N         (N),
    .MODE      (MODE),
    .LSB_FIRST (LSB_FIRST)
  ) u_search (
    .req_i   (bus.req),
    .base_i  (w_ptr),
    .idx_o   (w_win_idx),
    .zero_o  (w_win_zero),
    .multi_o (w_win_multi)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
    zero_d      = zero_q;
    multi_d     = multi_q;
    if (w_accept) begin
      out_valid_d = 1'b1;
      idx_d       = w_win_idx;
      zero_d      = w_win_zero;
      multi_d     = w_win_multi;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      zero_q      <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      zero_q      <= zero_d;
      multi_q     <= multi_d;
    end
  end

  if (MODE == MODE_RR) begin : g_ptr_rr
    logic [IW-1:0] ptr_q, ptr_d;

    // Next search begins just past the winner; an empty request leaves it alone.
    always_comb begin
      ptr_d = ptr_q;
      if (w_accept && !w_win_zero) begin
        ptr_d = (w_win_idx == IW'(N - 1)) ? '0 : w_win_idx + IW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
    end

    assign w_ptr = ptr_q;
  end else begin : g_ptr_fixed
    assign w_ptr = '0;
  end

`ifdef ENC_MULTI_CNT_EN
  logic [MULTI_CNT_W-1:0] multi_cnt_q, multi_cnt_d;

  always_comb begin
    multi_cnt_d = multi_cnt_q;
    if (w_accept && w_win_multi && (multi_cnt_q != '1)) begin
      multi_cnt_d = multi_cnt_q + MULTI_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) multi_cnt_q <= '0;
    else     multi_cnt_q <= multi_cnt_d;
  end

  assign bus.multi_cnt = multi_cnt_q;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.idx       = idx_q;
  assign bus.zero      = zero_q;
  assign bus.multi     = multi_q;

endmodule
`default_nettype wire
